butt_out_conv: RTL and testbench

BUTT_OUT_CONV -- requirements
Module: butt_out_conv

---
 rtl/butt_pkg.sv | 16 +
 rtl/butt_conv_fifo.sv | 95 +++++++++
 rtl/butt_out_conv.sv | 66 ++++++
 tb/tb_butt_out_conv.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/butt_pkg.sv
// Shared constants for the Butterworth signed-digit output converter.
// Digit i of a signed-digit word sits at bits [2i+1:2i] as {plus, minus}.
package butt_pkg;

  localparam int PLUS_BIT   = 1;
  localparam int MINUS_BIT  = 0;
  localparam int STAGE_DEF  = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int DROP_CNT_W = 8;

  // Bit position of one half (plus or minus) of signed digit 'digit'.
  function automatic int sd_idx(input int digit, input int half);
    return 2 * digit + half;
  endfunction

endpackage

// File: rtl/butt_conv_fifo.sv
// First-word-fall-through output buffer with occupancy, sticky overflow and
// an optional saturating drop counter (enabled by BUTT_CONV_DROPCNT_EN).
module butt_conv_fifo
  import butt_pkg::*;
#(
  parameter int W     = STAGE_DEF + 1,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  push,
  input  logic [W-1:0]          din,
  input  logic                  pop_req,
  output logic [W-1:0]          dout,
  output logic                  dout_valid,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [W-1:0]     head_reg, head_next;
  logic             overflow_reg;
  logic             full, empty, pop, wr, drop;

  always_comb begin
    full        = (count_reg == CNT_W'(DEPTH));
    empty       = (count_reg == '0);
    pop         = pop_req && !empty;
    // A full buffer still accepts a push when the head leaves on the same edge.
    wr          = push && (!full || pop);
    drop        = push && full && !pop;
    rd_ptr_next = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next  = count_reg;
    case ({wr, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
    // Registered head; bypass the write data when it becomes the new head.
    if (count_next == '0)
      head_next = '0;
    else if (wr && (wr_ptr_reg == rd_ptr_next))
      head_next = din;
    else
      head_next = mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (!nrst && wr)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      if (drop)
        overflow_reg <= 1'b1;
    end
  end

`ifdef BUTT_CONV_DROPCNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (nrst)
      drop_cnt_reg <= '0;
    else if (drop && (drop_cnt_reg != '1))
      drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = '0;
`endif

  assign dout       = head_reg;
  assign dout_valid = !empty;
  assign overflow   = overflow_reg;

endmodule

// File: rtl/butt_out_conv.sv
// Signed-digit to two's-complement converter feeding an FWFT output buffer.
// Optional drop counter is built when BUTT_CONV_DROPCNT_EN is defined.
module butt_out_conv
  import butt_pkg::*;
#(
  parameter int Stage = STAGE_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enable,
  input  logic [2*Stage-1:0]    din_sd,
  output logic [Stage:0]        dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [Stage-1:0] p_next, n_next;
  logic [Stage-1:0] p_reg, n_reg;
  logic [Stage:0]   diff_reg;
  logic             v1_reg, v2_reg;

  generate
    for (genvar gi = 0; gi < Stage; gi++) begin : g_gather
      assign p_next[gi] = din_sd[sd_idx(gi, PLUS_BIT)];
      assign n_next[gi] = din_sd[sd_idx(gi, MINUS_BIT)];
    end
  endgenerate

  // P and N are both non-negative, so one extra bit holds P-N exactly.
  always_ff @(posedge clk) begin
    if (nrst) begin
      p_reg    <= '0;
      n_reg    <= '0;
      v1_reg   <= 1'b0;
      diff_reg <= '0;
      v2_reg   <= 1'b0;
    end else begin
      v1_reg <= enable;
      if (enable) begin
        p_reg <= p_next;
        n_reg <= n_next;
      end
      diff_reg <= {1'b0, p_reg} - {1'b0, n_reg};
      v2_reg   <= v1_reg;
    end
  end

  butt_conv_fifo #(
    .W     (Stage + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .nrst       (nrst),
    .push       (v2_reg),
    .din        (diff_reg),
    .pop_req    (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

endmodule

// File: tb/tb_butt_out_conv.sv
// Directed scoreboard bench for butt_out_conv (Stage=8, DEPTH=4).
// Expected drop count follows BUTT_CONV_DROPCNT_EN.
module tb_butt_out_conv;

  logic       clk = 1'b0;
  logic       nrst;
  logic       enable;
  logic [15:0] din_sd;
  logic [8:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       overflow;
  logic [7:0] drop_cnt;

  int         n_asserts = 0;
  int         n_fail    = 0;
  int         n_out     = 0;
  logic [8:0] sb_q[$];
  bit         keep;
  logic [7:0] rp, rm;

`ifdef BUTT_CONV_DROPCNT_EN
  localparam int EXP_DROP = 2;
`else
  localparam int EXP_DROP = 0;
`endif

  always #5 clk = ~clk;

  butt_out_conv #(.Stage(8), .DEPTH(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (enable),
    .din_sd     (din_sd),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  function automatic logic [15:0] enc(input logic [7:0] p, input logic [7:0] m);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = p[i];
      r[2*i]   = m[i];
    end
    return r;
  endfunction

  function automatic logic [8:0] expv(input logic [7:0] p, input logic [7:0] m);
    return {1'b0, p} - {1'b0, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs; a pop happening on the coming edge is scored.
  task automatic tick(input logic en, input logic [7:0] p, input logic [7:0] m,
                      input logic rdy);
    enable     = en;
    din_sd     = enc(p, m);
    dout_ready = rdy;
    if (!nrst && dout_valid && rdy) begin
      if (sb_q.size() == 0) begin
        chk("stale_output", 32'(dout_valid), 32'd0);
      end else begin
        $display("out %0d: dout=%h expected=%h", n_out, dout, sb_q[0]);
        chk("dout", 32'(dout), 32'(sb_q.pop_front()));
      end
      n_out++;
    end
    if (en && keep)
      sb_q.push_back(expv(p, m));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() > 0; i++)
      tick(1'b0, 8'h00, 8'h00, 1'b1);
    chk("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; enable = 1'b0; din_sd = '0; dout_ready = 1'b0; keep = 1'b1;
    repeat (2) tick(1'b0, 8'h00, 8'h00, 1'b0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    nrst = 1'b0;

    // Latency: visible only after the third edge.
    tick(1'b1, 8'hFF, 8'h00, 1'b1);
    chk("lat_e1_valid", 32'(dout_valid), 32'd0);
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    chk("lat_e2_valid", 32'(dout_valid), 32'd0);
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    chk("lat_e3_valid", 32'(dout_valid), 32'd1);
    chk("lat_e3_dout", 32'(dout), 32'h0FF);
    drain();

    // Conversion patterns, back to back.
    tick(1'b1, 8'h00, 8'hFF, 1'b1);
    tick(1'b1, 8'h80, 8'h01, 1'b1);
    tick(1'b1, 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      rp = 8'($urandom);
      rm = 8'($urandom);
      tick(1'b1, rp, rm, 1'b1);
    end
    drain();
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    chk("empty_pop_valid", 32'(dout_valid), 32'd0);
    chk("no_overflow_yet", 32'(overflow), 32'd0);

    // Overflow: six samples into a four-entry buffer with no consumer.
    for (int i = 0; i < 6; i++) begin
      keep = (i < 4);
      tick(1'b1, 8'(i + 1), 8'h00, 1'b0);
    end
    keep = 1'b1;
    repeat (3) tick(1'b0, 8'h00, 8'h00, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_valid", 32'(dout_valid), 32'd1);
    chk("ovf_head", 32'(dout), 32'd1);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'(EXP_DROP));
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    chk("hold_head", 32'(dout), 32'd1);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full buffer with consumer and continuous input: no drops.
    for (int i = 0; i < 4; i++)
      tick(1'b1, 8'(8'h10 + i), 8'h00, 1'b0);
    repeat (2) tick(1'b0, 8'h00, 8'h00, 1'b0);
    chk("full_valid", 32'(dout_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("stream_valid", 32'(dout_valid), 32'd1);
      tick(1'b1, 8'(8'h20 + i), 8'h01, 1'b1);
    end
    drain();
    chk("stream_drop_cnt", 32'(drop_cnt), 32'(EXP_DROP));

    // Reset with three buffered and two in flight.
    keep = 1'b0;
    for (int i = 0; i < 5; i++)
      tick(1'b1, 8'(8'h40 + i), 8'h00, 1'b0);
    keep = 1'b1;
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    nrst = 1'b1;
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    nrst = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 8'h00, 8'h00, 1'b1);
      chk("post_rst_idle", 32'(dout_valid), 32'd0);
    end

    // Function still intact after reset.
    tick(1'b1, 8'h55, 8'h0A, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
